// File: rtl/seq_chunk_adder.sv
// +----------------------------------------------------------------------------+
// | seq_chunk_adder                                                            |
// | Multi-cycle ripple adder/subtractor: CHUNK bits per clock, LSB chunk first |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int c_nchunk = WIDTH / CHUNK;
  localparam int c_idxw   = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
  localparam logic [c_idxw-1:0] c_last = c_idxw'(c_nchunk - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_res;
  logic              r_cy;
  logic [c_idxw-1:0] r_idx;

  logic [CHUNK:0]    w_chunk;
  logic              w_cmsb;
  logic              w_last;
  logic [WIDTH-1:0]  w_a_nxt;
  logic [WIDTH-1:0]  w_b_nxt;
  logic [WIDTH-1:0]  w_res_nxt;

  // Operands shift right each cycle so the active chunk always sits at bit 0.
  assign w_chunk = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_cy};
  assign w_cmsb  = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk[CHUNK-1];
  assign w_last  = (r_idx == c_last);

  generate
    if (c_nchunk == 1) begin : g_single
      assign w_a_nxt   = r_a;
      assign w_b_nxt   = r_b;
      assign w_res_nxt = w_chunk[CHUNK-1:0];
    end else begin : g_multi
      assign w_a_nxt   = {{CHUNK{1'b0}}, r_a[WIDTH-1:CHUNK]};
      assign w_b_nxt   = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
      assign w_res_nxt = {w_chunk[CHUNK-1:0], r_res[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (start) w_state_nxt = c_st_run;
      c_st_run:  if (w_last) w_state_nxt = c_st_done;
      c_st_done: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state == c_st_run);
    done = (r_state == c_st_done);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cy     <= 1'b0;
      r_idx    <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (r_state == c_st_idle && start) begin
      // Subtraction becomes a + ~b + !cin.
      r_a   <= a;
      r_b   <= sub ? ~b : b;
      r_cy  <= sub ? ~cin : cin;
      r_idx <= '0;
    end else if (r_state == c_st_run) begin
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_res <= w_res_nxt;
      r_cy  <= w_chunk[CHUNK];
      r_idx <= r_idx + 1'b1;
      if (w_last) begin
        sum      <= w_res_nxt;
        carry    <= w_chunk[CHUNK];
        overflow <= w_cmsb ^ w_chunk[CHUNK];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
// +----------------------------------------------------------------------------+
// | tb_seq_chunk_adder                                                         |
// | Directed and random checks of seq_chunk_adder at 16/4 and 4/4              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16, start16, sub16, cin16, busy16, done16, carry16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        rst4, start4, sub4, cin4, busy4, done4, carry4, ovf4;
  logic [3:0]  a4, b4, sum4;

  int total = 0;
  int bad   = 0;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst16), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .carry(carry16),
    .overflow(ovf16)
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .carry(carry4),
    .overflow(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge, idle.
  task automatic run16(input string tag, input logic s, input logic [15:0] av,
                       input logic [15:0] bv, input logic c, input logic [15:0] es,
                       input logic ec, input logic eo);
    int lat;
    int bc;
    sub16 = s; a16 = av; b16 = bv; cin16 = c; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = ~av; b16 = 16'h0; cin16 = ~c; sub16 = ~s;
    lat = 0; bc = 0;
    while (!done16 && lat < 20) begin
      if (busy16) bc++;
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, 4);
    check({tag, ".busycycles"}, bc, 4);
    check({tag, ".sum"}, sum16, es);
    check({tag, ".carry"}, carry16, ec);
    check({tag, ".ovf"}, ovf16, eo);
    check({tag, ".busy_at_done"}, busy16, 0);
    @(negedge clk);
    check({tag, ".done_pulse"}, done16, 0);
  endtask

  task automatic run4(input string tag, input logic s, input logic [3:0] av,
                      input logic [3:0] bv, input logic c, input logic [3:0] es,
                      input logic ec, input logic eo);
    int lat;
    sub4 = s; a4 = av; b4 = bv; cin4 = c; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = ~av; b4 = ~bv;
    lat = 0;
    while (!done4 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, 1);
    check({tag, ".sum"}, sum4, es);
    check({tag, ".carry"}, carry4, ec);
    check({tag, ".ovf"}, ovf4, eo);
    @(negedge clk);
    check({tag, ".done_pulse"}, done4, 0);
  endtask

  initial begin
    int seen;
    int ai, bi, ci, sa, sb, raw, ss;
    logic s;
    rst16 = 1'b1; start16 = 0; sub16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    rst4  = 1'b1; start4  = 0; sub4  = 0; a4  = 0; b4  = 0; cin4  = 0;
    #1;
    check("reset.busy", busy16, 0);
    check("reset.done", done16, 0);
    check("reset.sum", sum16, 0);
    check("reset.carry", carry16, 0);
    check("reset.ovf", ovf16, 0);
    check("reset4.sum", sum4, 0);
    @(negedge clk);
    rst16 = 1'b0; rst4 = 1'b0;
    @(negedge clk);

    run16("t1", 0, 16'h1234, 16'h4321, 0, 16'h5555, 0, 0);
    run16("t2", 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
    run16("t3", 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    run16("t4a", 1, 16'h0005, 16'h0007, 0, 16'hFFFE, 0, 0);
    run16("t4b", 1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1);
    run16("t4c", 1, 16'h0010, 16'h0003, 1, 16'h000C, 1, 0);

    // Start held high through RUN and re-pulsed in DONE: both ignored.
    sub16 = 0; a16 = 16'h1111; b16 = 16'h2222; cin16 = 0; start16 = 1'b1;
    @(negedge clk);
    sub16 = 1; a16 = 16'hAAAA; b16 = 16'h5555;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start16 = 1'b0;
    seen = 0;
    while (!done16 && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    check("t5.ignored.sum", sum16, 16'h3333);
    check("t5.ignored.carry", carry16, 0);
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 0;
    @(negedge clk);
    start16 = 1'b0;
    check("t5.done_start_ignored", busy16, 0);
    @(negedge clk);

    // Abort after chunk 2 with asynchronous reset.
    sub16 = 0; a16 = 16'h1234; b16 = 16'h1111; cin16 = 0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst16 = 1'b1;
    #1;
    check("t5.rst.busy", busy16, 0);
    check("t5.rst.done", done16, 0);
    check("t5.rst.sum", sum16, 0);
    @(negedge clk);
    rst16 = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done16) seen++;
    end
    check("t5.rst.no_done", seen, 0);
    run16("t5.after", 0, 16'h0001, 16'h0001, 0, 16'h0002, 0, 0);

    run4("t6", 0, 4'd9, 4'd8, 1, 4'd2, 1, 1);
    run4("t6b", 1, 4'd3, 4'd5, 0, 4'hE, 0, 0);
    for (int n = 0; n < 200; n++) begin
      ai = $urandom_range(15);
      bi = $urandom_range(15);
      ci = $urandom_range(1);
      s  = 1'($urandom_range(1));
      sa = (ai >= 8) ? ai - 16 : ai;
      sb = (bi >= 8) ? bi - 16 : bi;
      if (!s) begin
        raw = ai + bi + ci;
        ss  = sa + sb + ci;
      end else begin
        raw = ai - bi - ci;
        ss  = sa - sb - ci;
      end
      run4("t6.rand", s, 4'(ai), 4'(bi), 1'(ci), 4'(raw & 15),
           s ? (raw >= 0) : (raw > 15), (ss > 7) || (ss < -8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
